minitb_arb: RTL
===============

Name: minitb_arb

Overview:
Round-robin arbiter and sequencer that shares the minitb 2-cycle delay-line datapath between NumReq requesters.
- Accepts one word per cycle from the winning requester over a valid/ready handshake.
- Drives the registered word into the datapath input and tracks the requester ID through the datapath latency.
- Routes each datapath output back to the originating requester.
- Sits between the requester ports and the datapath instance in the minitb design top.

Parameters:
NumReq, 4, number of requesters (2..16)
PipeLatency, 2, cycles from datapath valid_in sampled to valid_out asserted
MaxBurst, 4, max consecutive grants to one requester while others wait (1..255)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous active-high reset
enable  in  1  1 = new grants allowed; 0 = stop issuing, in-flight words drain
req_valid  in  NumReq  per-requester word available
req_data  in  NumReq x minitb::BusWidth  per-requester word
req_ready  out  NumReq  one-hot (or zero) grant; transfer when req_valid[i] & req_ready[i]
pipe_valid_in  out  1  to datapath valid_in
pipe_data_in  out  minitb::BusWidth  to datapath data_in
pipe_valid_out  in  1  from datapath valid_out
pipe_data_out  in  minitb::BusWidth  from datapath data_out
rsp_valid  out  NumReq  one-hot: result for requester i this cycle
rsp_data  out  minitb::BusWidth  result word, shared by all requesters
busy  out  1  any word in flight (issue register or tag pipe)
err  out  1  sticky: pipe_valid_out seen with no matching tag

Behaviour:
- Reset values:
  - Registered outputs pipe_valid_in, pipe_data_in, rsp_valid, rsp_data, busy and err are 0.
  - Tag pipe is cleared, burst count is 0, state is IDLE.
  - RR pointer (last granted) is NumReq-1, so requester 0 wins first.
  - req_ready is 0 during any cycle in which reset is high.
- req_ready is combinational from req_valid, state and pointer. No combinational path from req_valid[i] to req_ready[j] of a different requester other than through the arbitration mux.
- State machine:
  - IDLE: grant the first i with req_valid[i], searching from pointer+1 with wrap. On transfer, go to BURST with owner=i, count=1, pointer=i.
  - BURST: if req_valid[owner] and (count<MaxBurst or no other requester valid), keep granting owner and increment count, saturating at MaxBurst.
  - BURST, otherwise: perform an RR search from owner+1 exactly as in IDLE and restart count=1. If no requester is valid, go to IDLE.
- enable=0: req_ready=0 and state is held. Tags and pipe_valid_in continue draining.
- Issue: a transfer in cycle t gives pipe_valid_in=1 and pipe_data_in=word in cycle t+1. The tag {valid=1, id} is launched with it.
- Tag pipe:
  - Shift register of depth PipeLatency, so the tag aligns with pipe_valid_out in cycle t+1+PipeLatency.
  - When pipe_valid_out and the aligned tag are both valid: rsp_valid[id]=1 and rsp_data=pipe_data_out, registered, so visible at t+2+PipeLatency.
  - If pipe_valid_out=1 with no valid tag: set err; no rsp_valid.
  - If a tag is valid but pipe_valid_out=0: set err; the tag is dropped.
- Reset mid-operation: all in-flight tags are discarded. Because the datapath has no reset, err checking is masked for PipeLatency cycles after reset deasserts. Words in flight at reset are lost.
- Throughput: 1 word/cycle sustained, with no bubbles on grant switch.
- busy = pipe_valid_in | any tag valid.

Decomposition:
- Package minitb gains:
  - ReqIdWidth = $clog2(NumReq) as a localparam function or constant.
  - A tag_t struct {logic valid; logic [ReqIdWidth-1:0] id;}.
  - A DefaultPipeLatency constant = 2.
- BusWidth is reused from minitb.
- One sub-module, minitb_rr_pick: combinational round-robin priority pick (req vector, pointer → one-hot grant, found flag). It is reused by future arbiters.

Test Plan:
- Single requester: req 2 sends 5, 6, 7 back-to-back from cycle 10 → req_ready[2] high cycles 10-12; pipe_valid_in cycles 11-13; rsp_valid[2] with rsp_data 5, 6, 7 in cycles 14-16; busy low at 17.
- Fairness with MaxBurst=4: all 4 requesters continuously valid after reset → grant order 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0; each rsp routed to its own id.
- Burst extension: only req 1 valid for 10 cycles → 10 consecutive grants to 1; count saturates at 4; no gaps.
- enable pulse: enable=0 for cycles 20-24 with all requesters valid → req_ready=0 in 20-24; words issued before cycle 20 still complete; grants resume at 25 from the held owner/count.
- Reset mid-stream: reset at cycle 30 while 2 words in flight → no rsp_valid for them; err stays 0 despite stale pipe_valid_out in cycles 31-32.
- Fault injection: force pipe_valid_out=1 with the tag pipe empty → err=1 next cycle and stays 1 until reset; rsp_valid stays 0.

Source files
------------

// File: rtl/minitb_arb_pkg.sv
// Shared types and constants for the minitb round-robin arbiter slice.
package minitb_arb_pkg;
    localparam int BusWidth           = 8;
    localparam int DefaultPipeLatency = 2;
    localparam int MaxReqIdWidth      = 4;

    function automatic int req_id_width(input int num_req);
        return (num_req < 2) ? 1 : $clog2(num_req);
    endfunction

    // id is sized for the largest supported requester count (16)
    typedef struct packed {
        logic                     valid;
        logic [MaxReqIdWidth-1:0] id;
    } tag_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;
endpackage

// File: rtl/minitb_arb_if.sv
// Requester-side bus of the minitb arbiter: per-requester request handshake and shared response.
interface minitb_arb_if #(
    parameter int NumReq = 4
);
    // A word moves when req_valid[i] & req_ready[i] at a rising edge; req_ready never depends on
    // req_data, and rsp_valid is a one-cycle one-hot strobe with no back-pressure.
    logic [NumReq-1:0]                               req_valid;
    logic [NumReq-1:0][minitb_arb_pkg::BusWidth-1:0] req_data;
    logic [NumReq-1:0]                               req_ready;
    logic [NumReq-1:0]                               rsp_valid;
    logic [minitb_arb_pkg::BusWidth-1:0]             rsp_data;

    modport master (output req_valid, req_data, input req_ready, rsp_valid, rsp_data);
    modport slave  (input req_valid, req_data, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/minitb_rr_pick.sv
// Combinational round-robin pick: first set bit of req searching upward from ptr+1 with wrap.
module minitb_rr_pick #(
    parameter int NumReq  = 4,
    parameter int IdWidth = 2
) (
    input  logic [NumReq-1:0]  req,
    input  logic [IdWidth-1:0] ptr,
    output logic [NumReq-1:0]  grant,
    output logic               found
);
    logic [IdWidth-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NumReq; k++) begin
            idx = IdWidth'((int'(ptr) + k) % NumReq);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/minitb_arb.sv
// Round-robin burst arbiter feeding the minitb delay-line datapath and routing results back by tag.
module minitb_arb
    import minitb_arb_pkg::*;
#(
    parameter int NumReq      = 4,
    parameter int PipeLatency = DefaultPipeLatency,
    parameter int MaxBurst    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    minitb_arb_if.slave         bus,
    output logic                pipe_valid_in,
    output logic [BusWidth-1:0] pipe_data_in,
    input  logic                pipe_valid_out,
    input  logic [BusWidth-1:0] pipe_data_out,
    output logic                busy,
    output logic                err,
    output arb_state_t          arb_state
);
    localparam int IdW   = req_id_width(NumReq);
    localparam int CntW  = 8;
    localparam int MaskW = 8;

    arb_state_t          state_q, state_d;
    logic [IdW-1:0]      ptr_q, ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [NumReq-1:0]   pick_grant, owner_oh, grant, rsp_hit_oh, rsp_valid_q;
    logic                pick_found, keep, found, others_valid, xfer, tags_any;
    logic [IdW-1:0]      grant_id;
    logic [BusWidth-1:0] grant_word, rsp_data_q;
    logic [MaskW-1:0]    mask_q;
    tag_t                issue_tag, aligned;
    tag_t                tag_pipe [PipeLatency];

    minitb_rr_pick #(.NumReq(NumReq), .IdWidth(IdW)) u_pick (
        .req   (bus.req_valid),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .found (pick_found)
    );

    // ptr_q doubles as the burst owner while in ST_BURST
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= IdW'(NumReq - 1);
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        owner_oh        = '0;
        owner_oh[ptr_q] = 1'b1;
        others_valid    = |(bus.req_valid & ~owner_oh);
        keep  = (state_q == ST_BURST) && bus.req_valid[ptr_q]
                && ((count_q < CntW'(MaxBurst)) || !others_valid);
        grant = keep ? owner_oh : pick_grant;
        found = keep || pick_found;
        grant_id = ptr_q;
        for (int i = 0; i < NumReq; i++) begin
            if (grant[i]) grant_id = IdW'(i);
        end
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (enable) begin
            if (found) begin
                state_d = ST_BURST;
                ptr_d   = grant_id;
                count_d = !keep ? CntW'(1)
                        : (count_q == CntW'(MaxBurst)) ? count_q : count_q + 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        bus.req_ready = (enable && !reset) ? grant : '0;
        arb_state     = state_q;
    end

    always_comb begin
        xfer       = |(bus.req_ready & bus.req_valid);
        grant_word = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (bus.req_ready[i]) grant_word = bus.req_data[i];
        end
        aligned  = tag_pipe[PipeLatency-1];
        tags_any = 1'b0;
        for (int i = 0; i < PipeLatency; i++) begin
            tags_any = tags_any | tag_pipe[i].valid;
        end
        rsp_hit_oh = '0;
        if (pipe_valid_out && aligned.valid) begin
            for (int i = 0; i < NumReq; i++) begin
                if (aligned.id == MaxReqIdWidth'(i)) rsp_hit_oh[i] = 1'b1;
            end
        end
    end

    // The datapath itself has no reset, so its output is ignored for PipeLatency cycles after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid_in <= 1'b0;
            pipe_data_in  <= '0;
            issue_tag     <= '0;
            for (int i = 0; i < PipeLatency; i++) tag_pipe[i] <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            busy          <= 1'b0;
            err           <= 1'b0;
            mask_q        <= MaskW'(PipeLatency);
        end else begin
            pipe_valid_in   <= xfer;
            if (xfer) pipe_data_in <= grant_word;
            issue_tag.valid <= xfer;
            issue_tag.id    <= MaxReqIdWidth'(grant_id);
            tag_pipe[0]     <= issue_tag;
            for (int i = 1; i < PipeLatency; i++) tag_pipe[i] <= tag_pipe[i-1];
            busy        <= pipe_valid_in | tags_any;
            rsp_valid_q <= rsp_hit_oh;
            if (pipe_valid_out && aligned.valid) rsp_data_q <= pipe_data_out;
            if (mask_q != '0) begin
                mask_q <= mask_q - 1'b1;
            end else if (pipe_valid_out != aligned.valid) begin
                err <= 1'b1;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule
